// File: rtl/proc_pkg.sv
// Shared definitions for processor_param: opcodes, FSM states, helpers.
// No ports. Used by proc_alu and processor_param.
package proc_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_SHR = 4'b0111;
  localparam logic [3:0] OP_OUT = 4'b1000;
  localparam logic [3:0] OP_MV  = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EX1  = 2'd1,
    S_EX2  = 2'd2,
    S_EX3  = 2'd3
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  // Opcodes that take the three-cycle EX1/EX2/EX3 path.
  function automatic logic is_alu(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_AND) || (op == OP_OR)  ||
           (op == OP_XOR) || (op == OP_SHL) ||
           (op == OP_SHR);
  endfunction

endpackage

// File: rtl/proc_alu.sv
// Combinational ALU for processor_param.
// Ports: op, a, b in; result, carry out (carry/borrow/last shifted-out bit).
module proc_alu
  import proc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  localparam int SW = clog2(DATA_W);

  logic [SW-1:0] sh;

  assign sh = b[SW-1:0];

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: {carry, result} = {1'b0, a} + {1'b0, b};
      OP_SUB: {carry, result} = {1'b0, a} - {1'b0, b};
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      // Extra bit beside the word catches the last bit shifted out.
      OP_SHL: {carry, result} = {1'b0, a} << sh;
      OP_SHR: {result, carry} = {a, 1'b0} >> sh;
      default: ;
    endcase
  end

endmodule

// File: rtl/signal_extender.sv
// Sign extender from IN_W to OUT_W bits.
// Ports: din (IN_W) in, dout (OUT_W) out. Truncates if OUT_W <= IN_W.
module signal_extender #(
  parameter int IN_W  = 9,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout
);

  if (OUT_W > IN_W) begin : g_ext
    assign dout = {{(OUT_W-IN_W){din[IN_W-1]}}, din};
  end else begin : g_trunc
    assign dout = din[OUT_W-1:0];
  end

endmodule

// File: rtl/processor_param.sv
// Parametrised multicycle accumulator core with valid/ready instruction input.
// Ports: clock, resetn, iin/iin_valid/iin_ready, bus, out_valid, done, flags (PROC_FLAGS_EN only).
module processor_param
  import proc_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int NREG    = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [INSTR_W-1:0] iin,
  input  logic               iin_valid,
  output logic               iin_ready,
  output logic [DATA_W-1:0]  bus,
  output logic               out_valid,
  output logic               done
`ifdef PROC_FLAGS_EN
  ,
  output logic [1:0]         flags
`endif
);

  localparam int RA    = clog2(NREG);
  localparam int IMM_W = INSTR_W - 4 - RA;

  state_t state;
  state_t state_nx;

  logic [INSTR_W-1:0] ir;
  logic [DATA_W-1:0]  regs [NREG];
  logic [DATA_W-1:0]  a_q;
  logic [DATA_W-1:0]  g_q;

  logic [3:0]        op;
  logic [RA-1:0]     rx;
  logic [RA-1:0]     ry;
  logic [IMM_W-1:0]  imm_raw;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] rx_val;
  logic [DATA_W-1:0] ry_val;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;

  assign op      = ir[INSTR_W-1 -: 4];
  assign rx      = ir[INSTR_W-5 -: RA];
  assign ry      = ir[INSTR_W-5-RA -: RA];
  assign imm_raw = ir[IMM_W-1:0];
  assign rx_val  = regs[rx];
  assign ry_val  = regs[ry];

  signal_extender #(
    .IN_W  (IMM_W),
    .OUT_W (DATA_W)
  ) u_sx (
    .din  (imm_raw),
    .dout (imm)
  );

  proc_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op     (op),
    .a      (a_q),
    .b      (ry_val),
    .result (alu_res),
    .carry  (alu_c)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (iin_valid) state_nx = S_EX1;
      S_EX1:   state_nx = is_alu(op) ? S_EX2 : S_IDLE;
      S_EX2:   state_nx = S_EX3;
      S_EX3:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Ready is held low while reset is asserted, not just in IDLE.
  always_comb begin
    iin_ready = resetn && (state == S_IDLE);
    done      = ((state == S_EX1) && !is_alu(op)) ||
                (state == S_EX3);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ir        <= '0;
      a_q       <= '0;
      g_q       <= '0;
      bus       <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: if (iin_valid) ir <= iin;
        S_EX1: begin
          case (op)
            OP_LDI: regs[rx] <= imm;
            OP_MV:  regs[rx] <= ry_val;
            OP_OUT: begin
              bus       <= rx_val;
              out_valid <= 1'b1;
            end
            default: if (is_alu(op)) a_q <= rx_val;
          endcase
        end
        // bus takes the result together with G so it shows G in EX3.
        S_EX2: begin
          g_q <= alu_res;
          bus <= alu_res;
        end
        S_EX3: regs[rx] <= g_q;
        default: ;
      endcase
    end
  end

`ifdef PROC_FLAGS_EN
  logic c_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      c_q   <= 1'b0;
      flags <= 2'b00;
    end else if (state == S_EX2) begin
      c_q <= alu_c;
    end else if (state == S_EX3) begin
      flags <= {c_q, (g_q == '0)};
    end
  end
`else
  logic carry_unused;

  assign carry_unused = alu_c;
`endif

endmodule
